// File: rtl/capt_ctrl.sv
// capt_ctrl: capture/dump controller for one sample RAM channel.
// Optional feature macro CAPT_AUTO_REARM_EN: re-arm capture after a dump.
module capt_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            triggered,
  input  logic            wrt_smpl,
  input  logic [LOG2-1:0] trig_pos,
  input  logic            dump_req,
  input  logic            resp_sent,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] raddr,
  output logic            armed,
  output logic            capt_done,
  output logic            send_resp,
  output logic            dumping
);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DONE, S_DUMP} state_t;
  typedef enum logic [1:0] {D_LAT, D_SEND, D_WAIT} dph_t;

  localparam logic [LOG2-1:0] L_LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   L_ENT  = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2+1:0] L_ENTW = (LOG2+2)'(ENTRIES);

  state_t          r_state, w_state_nxt;
  dph_t            r_dph, w_dph_nxt;
  logic [LOG2-1:0] r_waddr, w_waddr_nxt;
  logic [LOG2-1:0] r_raddr, w_raddr_nxt;
  logic [LOG2-1:0] r_start, w_start_nxt;
  logic [LOG2-1:0] r_trig_cnt, w_trig_cnt_nxt;
  logic [LOG2:0]   r_smpl_cnt, w_smpl_cnt_nxt;
  logic [LOG2:0]   r_dump_cnt, w_dump_cnt_nxt;
  logic            r_trig_lat, w_trig_lat_nxt;
  logic            w_restart;

  logic [LOG2-1:0] w_tp;
  logic [LOG2-1:0] w_waddr_inc;
  logic [LOG2-1:0] w_raddr_inc;
  logic            w_armed;
  logic            w_trig_hit;
  logic            w_post_hit;
  logic            w_dump_last;

  assign w_tp = ({1'b0, trig_pos} >= L_ENT) ? L_LAST : trig_pos;

  assign w_waddr_inc = (r_waddr == L_LAST) ? '0 : r_waddr + LOG2'(1);
  assign w_raddr_inc = (r_raddr == L_LAST) ? '0 : r_raddr + LOG2'(1);

  assign w_armed = (r_state == S_CAPT) &&
                   (({1'b0, r_smpl_cnt} + {2'b00, w_tp}) >= L_ENTW);

  assign w_trig_hit = triggered & w_armed & ~r_trig_lat;

  assign w_post_hit = r_trig_lat & wrt_smpl &
                      ((r_trig_cnt + LOG2'(1)) == w_tp);

  assign w_dump_last = (r_dump_cnt + (LOG2+1)'(1)) == L_ENT;

  assign waddr     = r_waddr;
  assign raddr     = r_raddr;
  assign armed     = w_armed;
  assign capt_done = (r_state == S_DONE) | (r_state == S_DUMP);
  assign dumping   = (r_state == S_DUMP);

  // Next-state, next-datapath and strobe outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_dph_nxt      = r_dph;
    w_waddr_nxt    = r_waddr;
    w_raddr_nxt    = r_raddr;
    w_start_nxt    = r_start;
    w_trig_cnt_nxt = r_trig_cnt;
    w_smpl_cnt_nxt = r_smpl_cnt;
    w_dump_cnt_nxt = r_dump_cnt;
    w_trig_lat_nxt = r_trig_lat;
    w_restart      = 1'b0;
    we             = 1'b0;
    send_resp      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_nxt = S_CAPT;
          w_restart   = 1'b1;
        end
      end
      S_CAPT: begin
        if (!run) begin
          w_state_nxt = S_IDLE;
        end else begin
          we = wrt_smpl;
          if (wrt_smpl) begin
            w_waddr_nxt = w_waddr_inc;
            if (r_smpl_cnt != L_ENT) begin
              w_smpl_cnt_nxt = r_smpl_cnt + (LOG2+1)'(1);
            end
          end
          if (w_trig_hit) begin
            w_trig_lat_nxt = 1'b1;
            if (w_tp == '0) begin
              w_state_nxt = S_DONE;
              w_start_nxt = wrt_smpl ? w_waddr_inc : r_waddr;
            end
          end else if (r_trig_lat && wrt_smpl) begin
            w_trig_cnt_nxt = r_trig_cnt + LOG2'(1);
            if (w_post_hit) begin
              w_state_nxt = S_DONE;
              w_start_nxt = w_waddr_inc;
            end
          end
        end
      end
      S_DONE: begin
        if (!run) begin
          w_state_nxt = S_IDLE;
        end else if (dump_req) begin
          w_state_nxt    = S_DUMP;
          w_raddr_nxt    = r_start;
          w_dump_cnt_nxt = '0;
          w_dph_nxt      = D_LAT;
        end
      end
      S_DUMP: begin
        unique case (r_dph)
          D_LAT: w_dph_nxt = D_SEND;
          D_SEND: begin
            send_resp = 1'b1;
            w_dph_nxt = D_WAIT;
          end
          D_WAIT: begin
            if (resp_sent) begin
              w_raddr_nxt    = w_raddr_inc;
              w_dump_cnt_nxt = r_dump_cnt + (LOG2+1)'(1);
              w_dph_nxt      = D_LAT;
              if (w_dump_last) begin
`ifdef CAPT_AUTO_REARM_EN
                if (run) begin
                  w_state_nxt = S_CAPT;
                  w_restart   = 1'b1;
                end else begin
                  w_state_nxt = S_DONE;
                end
`else
                w_state_nxt = S_DONE;
`endif
              end
            end
          end
          default: w_dph_nxt = D_LAT;
        endcase
      end
    endcase
    if (w_restart) begin
      w_waddr_nxt    = '0;
      w_smpl_cnt_nxt = '0;
      w_trig_cnt_nxt = '0;
      w_trig_lat_nxt = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dph      <= D_LAT;
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_start    <= '0;
      r_trig_cnt <= '0;
      r_smpl_cnt <= '0;
      r_dump_cnt <= '0;
      r_trig_lat <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dph      <= w_dph_nxt;
      r_waddr    <= w_waddr_nxt;
      r_raddr    <= w_raddr_nxt;
      r_start    <= w_start_nxt;
      r_trig_cnt <= w_trig_cnt_nxt;
      r_smpl_cnt <= w_smpl_cnt_nxt;
      r_dump_cnt <= w_dump_cnt_nxt;
      r_trig_lat <= w_trig_lat_nxt;
    end
  end

endmodule

// File: tb/tb_capt_ctrl.sv
// tb_capt_ctrl: directed and random checks of capt_ctrl
// against a write-count / byte-count reference model.
module tb_capt_ctrl;

  localparam int E  = 384;
  localparam int LG = 9;

  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_DONE = 2;
  localparam int M_DUMP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          triggered = 1'b0;
  logic          wrt_smpl = 1'b0;
  logic [LG-1:0] trig_pos = '0;
  logic          dump_req = 1'b0;
  logic          resp_sent = 1'b0;
  logic          we;
  logic [LG-1:0] waddr;
  logic [LG-1:0] raddr;
  logic          armed;
  logic          capt_done;
  logic          send_resp;
  logic          dumping;

  int n_chk  = 0;
  int n_pass = 0;

  int m_mode  = M_IDLE;
  int m_nw    = 0;
  int m_tw    = 0;
  int m_start = 0;
  int m_rbase = 0;
  int m_byte  = 0;
  int m_ph    = 0;
  bit m_trig  = 1'b0;

  int sr [E];

  always #5 clk = ~clk;

  capt_ctrl #(
    .ENTRIES(E),
    .LOG2   (LG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .triggered(triggered),
    .wrt_smpl (wrt_smpl),
    .trig_pos (trig_pos),
    .dump_req (dump_req),
    .resp_sent(resp_sent),
    .we       (we),
    .waddr    (waddr),
    .raddr    (raddr),
    .armed    (armed),
    .capt_done(capt_done),
    .send_resp(send_resp),
    .dumping  (dumping)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int eff_tp();
    return (int'(trig_pos) >= E) ? E - 1 : int'(trig_pos);
  endfunction

  function automatic int m_armed();
    int held;
    held = (m_nw < E) ? m_nw : E;
    return int'(m_mode == M_CAP && held + eff_tp() >= E);
  endfunction

  task automatic compare();
    chk("we", int'(we), int'(m_mode == M_CAP && run && wrt_smpl));
    chk("armed", int'(armed), m_armed());
    chk("capt_done", int'(capt_done),
        int'(m_mode == M_DONE || m_mode == M_DUMP));
    chk("send_resp", int'(send_resp), int'(m_mode == M_DUMP && m_ph == 1));
    chk("dumping", int'(dumping), int'(m_mode == M_DUMP));
    chk("waddr", int'(waddr), m_nw % E);
    chk("raddr", int'(raddr), (m_rbase + m_byte) % E);
  endtask

  task automatic model_step();
    int tp;
    int arm;
    bit was;
    tp  = eff_tp();
    arm = m_armed();
    if (rst) begin
      m_mode = M_IDLE; m_nw = 0; m_tw = 0; m_trig = 0;
      m_start = 0; m_rbase = 0; m_byte = 0; m_ph = 0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (run) begin
          m_mode = M_CAP; m_nw = 0; m_trig = 0;
        end
      end
      M_CAP: begin
        if (!run) begin
          m_mode = M_IDLE;
        end else begin
          was = m_trig;
          if (wrt_smpl) m_nw++;
          if (!was && triggered && arm != 0) begin
            m_trig = 1;
            m_tw   = m_nw;
            if (tp == 0) begin
              m_mode = M_DONE; m_start = m_nw % E;
            end
          end else if (was && wrt_smpl && (m_nw - m_tw) == tp) begin
            m_mode = M_DONE; m_start = m_nw % E;
          end
        end
      end
      M_DONE: begin
        if (!run) m_mode = M_IDLE;
        else if (dump_req) begin
          m_mode = M_DUMP; m_rbase = m_start; m_byte = 0; m_ph = 0;
        end
      end
      default: begin
        if (m_ph < 2) m_ph++;
        else if (resp_sent) begin
          m_byte++;
          m_ph = 0;
          if (m_byte == E) begin
`ifdef CAPT_AUTO_REARM_EN
            if (run) begin
              m_mode = M_CAP; m_nw = 0; m_trig = 0;
            end else m_mode = M_DONE;
`else
            m_mode = M_DONE;
`endif
          end
        end
      end
    endcase
  endtask

  task automatic cyc(input bit i_rst, input bit i_run, input bit i_tg,
                     input bit i_ws, input bit i_dr, input bit i_rs,
                     input int i_tp);
    @(negedge clk);
    rst       = i_rst;
    run       = i_run;
    triggered = i_tg;
    wrt_smpl  = i_ws;
    dump_req  = i_dr;
    resp_sent = i_rs;
    trig_pos  = LG'(i_tp);
    #1;
    compare();
    model_step();
  endtask

  function automatic bit resp_now();
    if (m_mode == M_DUMP && m_ph >= 2) return $urandom_range(0, 2) != 0;
    return 1'b0;
  endfunction

  initial begin
    int tp;
    int nwe;
    int ns;
    int nsr;
    bit r;
    bit run_lvl;

    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_outputs",
        int'({we, armed, capt_done, send_resp, dumping, waddr, raddr}), 0);

    // arming point and trigger at waddr 300
    tp = 128;
    cyc(0, 1, 0, 0, 0, 0, tp);
    for (int i = 0; i <= 300; i++) begin
      cyc(0, 1, (i == 100 || i == 255 || i == 300), 1, 0, 0, tp);
      if (i == 255) chk("armed_before_256", int'(armed), 0);
      if (i == 256) chk("armed_after_256", int'(armed), 1);
      if (i == 300) chk("trig_waddr", int'(waddr), 300);
    end
    nwe = 0;
    for (int j = 0; j < 400 && !capt_done; j++) begin
      cyc(0, 1, 0, 1, 0, 0, tp);
      if (we) nwe++;
    end
    chk("post_trig_writes", nwe, 128);
    chk("capt_done_set", int'(capt_done), 1);
    chk("model_start", m_start, 45);

    // full dump
    cyc(0, 1, 0, 0, 1, 0, tp);
    ns = 0;
    for (int k = 0; k < 5000; k++) begin
      cyc(0, 1, 0, 0, 0, resp_now(), tp);
      if (send_resp) begin
        if (ns < E) sr[ns] = int'(raddr);
        ns++;
      end
      if (!dumping) break;
    end
    chk("dump_count", ns, E);
    chk("dump_first", sr[0], 45);
    chk("dump_383", sr[338], 383);
    chk("dump_wrap0", sr[339], 0);
    chk("dump_last", sr[383], 44);
    chk("dump_end_dumping", int'(dumping), 0);
`ifdef CAPT_AUTO_REARM_EN
    chk("rearm_capt_done", int'(capt_done), 0);
    chk("rearm_armed", int'(armed), 0);
    chk("rearm_waddr", int'(waddr), 0);
`else
    chk("dump_end_done", int'(capt_done), 1);
`endif

    // abort after 100 writes
    cyc(0, 0, 0, 0, 0, 0, tp);
    cyc(0, 1, 0, 0, 0, 0, tp);
    for (int i = 0; i < 100; i++) cyc(0, 1, 0, 1, 0, 0, tp);
    cyc(0, 0, 0, 1, 0, 0, tp);
    chk("abort_we", int'(we), 0);
    cyc(0, 0, 0, 1, 0, 0, tp);
    chk("abort_we_idle", int'(we), 0);
    chk("abort_capt_done", int'(capt_done), 0);
    chk("abort_waddr", int'(waddr), 100);

    // reset at the 10th send_resp of a dump
    tp = 5;
    cyc(0, 1, 0, 0, 0, 0, tp);
    for (int j = 0; j < 1000 && !capt_done; j++) cyc(0, 1, 1, 1, 0, 0, tp);
    chk("short_done", int'(capt_done), 1);
    cyc(0, 1, 0, 0, 1, 0, tp);
    ns = 0;
    for (int k = 0; k < 500; k++) begin
      r = (m_mode == M_DUMP && m_ph == 1 && ns == 9);
      cyc(r, 1, 0, 0, 0, resp_now(), tp);
      if (send_resp) ns++;
      if (r) begin
        chk("send_at_rst", int'(send_resp), 1);
        break;
      end
    end
    chk("sends_before_rst", ns, 10);
    cyc(0, 0, 0, 0, 0, 0, tp);
    chk("rst_outputs",
        int'({we, armed, capt_done, send_resp, dumping, waddr, raddr}), 0);
    nsr = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0, 0, 0, (k % 2) == 0, (k % 3) == 0, tp);
      if (send_resp) nsr++;
    end
    chk("no_send_after_rst", nsr, 0);

    // randomized traffic
    run_lvl = 1'b1;
    for (int c = 0; c < 25000; c++) begin
      if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: tp = 0;
          1: tp = 1;
          2: tp = E - 1;
          3: tp = E;
          4: tp = 511;
          default: tp = int'($urandom_range(0, 511));
        endcase
      end
      if (run_lvl) begin
        if ($urandom_range(0, 1499) == 0) run_lvl = 1'b0;
        if (m_mode == M_DONE && $urandom_range(0, 49) == 0) run_lvl = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        run_lvl = 1'b1;
      end
      cyc($urandom_range(0, 3999) == 0,
          run_lvl,
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 29) == 0,
          (m_mode == M_DUMP && m_ph >= 2) ? $urandom_range(0, 1) == 0
                                          : $urandom_range(0, 39) == 0,
          tp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/capt_ctrl.md
CAPT_CTRL -- requirements
Module: capt_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384, sample RAM depth per channel (12288 on DE-0).
REQ-002 Parameter LOG2, default 9, RAM address width; the smallest value for which 2^LOG2 >= ENTRIES.
REQ-003 clk  input  1  system clock (100MHz); the one clock, all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 run  input  1  run bit from TrigCfg register.
REQ-006 triggered  input  1  trigger-logic detect pulse.
REQ-007 wrt_smpl  input  1  decimated sample-valid strobe.
REQ-008 trig_pos  input  LOG2  samples to capture after trigger.
REQ-009 dump_req  input  1  channel-dump command pulse from command handler.
REQ-010 resp_sent  input  1  UART transmit-done pulse.
REQ-011 we  output  1  RAM write enable.
REQ-012 waddr  output  LOG2  RAM write address.
REQ-013 raddr  output  LOG2  RAM read address.
REQ-014 armed  output  1  pre-trigger region filled; triggers accepted.
REQ-015 capt_done  output  1  capture complete.
REQ-016 send_resp  output  1  one-cycle request to transmit RAM read data.
REQ-017 dumping  output  1  high while in DUMP state.

Function
REQ-018 State machine states: IDLE, CAPTURE, DONE, DUMP.
REQ-019 IDLE, run=1: next state CAPTURE; waddr, smpl_cnt and trig_cnt cleared; trigger latch cleared.
REQ-020 CAPTURE, wrt_smpl=1: we=1 combinationally in the same cycle at the current waddr; waddr then advances and wraps from ENTRIES-1 to 0.
REQ-021 smpl_cnt increments on each write and saturates at ENTRIES; armed=1 when smpl_cnt+trig_pos >= ENTRIES.
REQ-022 triggered is latched only when armed=1; a trigger while armed=0 is ignored.
REQ-023 A sample written in the trigger-latch cycle is the trigger sample and is not counted.
REQ-024 After the latch, trig_cnt increments on each later write.
REQ-025 When trig_cnt reaches trig_pos, the next state is DONE; start_ptr is set to the post-write waddr (oldest sample).
REQ-026 trig_pos=0: next state DONE on the cycle after the trigger latch; no further writes.
REQ-027 trig_pos >= ENTRIES: clamped to ENTRIES-1.
REQ-028 run=0 during CAPTURE: abort to IDLE next cycle; we=0 in that cycle; capt_done stays 0.
REQ-029 DONE: capt_done=1 and we=0.
REQ-030 DONE, dump_req=1: next state DUMP; raddr loaded with start_ptr; dump_cnt cleared.
REQ-031 dump_req outside DONE is ignored.
REQ-032 DONE, run=0: next state IDLE; capt_done cleared.
REQ-033 DUMP: raddr is held for 1 cycle (RAM read latency), then send_resp is pulsed for exactly 1 cycle; the block then waits for resp_sent.
REQ-034 On resp_sent: raddr advances with wrap; dump_cnt increments; the next byte begins.
REQ-035 After ENTRIES bytes the next state is DONE.
REQ-036 resp_sent while not awaiting one is ignored.
REQ-037 Simultaneous run=0 and dump_req in DONE: run=0 wins and the next state is IDLE.

Reset
REQ-038 rst=1 at a rising clk edge: state IDLE; waddr, raddr, counters, start_ptr and trigger latch set to 0.
REQ-039 Reset values: we=0, armed=0, capt_done=0, send_resp=0, dumping=0.
REQ-040 Reset has priority over every other input, including mid-CAPTURE and mid-DUMP; a DUMP in progress is abandoned with no further send_resp.

Configuration
REQ-041 Macro CAPT_AUTO_REARM_EN defined: on dump completion with run=1, next state CAPTURE (counters cleared, as in REQ-019) instead of DONE; capt_done deasserts.
REQ-042 CAPT_AUTO_REARM_EN undefined: dump completion always returns to DONE (REQ-035).

Verification
REQ-043 ENTRIES=384, trig_pos=128, run=1, continuous wrt_smpl -> armed rises after the 256th write; triggered before that has no effect.
REQ-044 Trigger accepted at waddr=300 -> exactly 128 further writes; capt_done=1; start_ptr=45 ((300+1+128) mod 384).
REQ-045 dump_req in DONE -> 384 send_resp pulses, each answered by resp_sent; raddr sequence 45..383, 0..44; then DONE.
REQ-046 run=0 after 100 writes -> IDLE next cycle, no further we, capt_done=0.
REQ-047 rst=1 at the 10th send_resp of a dump -> all outputs 0 next cycle; no further send_resp.
REQ-048 CAPT_AUTO_REARM_EN defined, run held 1 -> after the 384th resp_sent, state CAPTURE, smpl_cnt=0, armed=0.
